mini_top_level: RTL and testbench

- Control-path slice of the single-cycle MIPS datapath.
- Decodes a 32-bit instruction through two stages in series:
  - a main controller, opcode to ALUOp/ALUSrc/RegWrite;
  - an ALU-control decoder, ALUOp plus funct to a 3-bit ALU operation.
- A single synchronous run flag qualifies the outputs so that nothing is asserted during or straight out of reset.
- Sits between instruction fetch and the ALU/register-file enables.

---
 rtl/mini_top_level_pkg.sv | 48 ++++
 rtl/mini_top_level_alu_control.sv | 31 +++
 rtl/mini_top_level_main_controller.sv | 30 +++
 rtl/mini_top_level.sv | 72 +++++++
 tb/tb_mini_top_level.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mini_top_level_pkg.sv
// Shared encodings for the MIPS control-path slice: opcodes, funct codes,
// ALUOp codes and ALU operation codes used by the controller and ALU decoder.
package mini_top_level_pkg;

    // Instruction opcodes, Instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes, Instruction[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUOp codes passed from the main controller to the ALU decoder
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_UNUSED = 2'b11;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Bundle of the main controller's decoded fields
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       regwrite;
    } main_ctrl_t;

    // Field extractors so both decoders slice the instruction identically
    function automatic logic [5:0] get_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] get_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/mini_top_level_alu_control.sv
// ALU control decoder: ALUOp plus funct to a 3-bit ALU operation, combinational.
module alu_control
    import mini_top_level_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Funct is only consulted for R-type; the unused ALUOp code yields AND (000)
    always_comb begin
        alucontrol = ALU_AND;
        case (aluop)
            ALUOP_ADD:   alucontrol = ALU_ADD;
            ALUOP_SUB:   alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_AND;
                endcase
            end
            ALUOP_UNUSED: alucontrol = ALU_AND;
            default:      alucontrol = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mini_top_level_main_controller.sv
// Main controller: opcode to ALUOp / ALUSrc / RegWrite, purely combinational.
module main_controller
    import mini_top_level_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] aluop,
    output logic       alusrc,
    output logic       regwrite
);

    main_ctrl_t ctrl;

    // Opcode lookup; unknown opcodes decode to a harmless no-write add
    always_comb begin
        ctrl = '{aluop: ALUOP_ADD, alusrc: 1'b0, regwrite: 1'b0};
        case (opcode)
            OP_RTYPE: ctrl = '{aluop: ALUOP_FUNCT, alusrc: 1'b0, regwrite: 1'b1};
            OP_LW:    ctrl = '{aluop: ALUOP_ADD,   alusrc: 1'b1, regwrite: 1'b1};
            OP_SW:    ctrl = '{aluop: ALUOP_ADD,   alusrc: 1'b1, regwrite: 1'b0};
            OP_BEQ:   ctrl = '{aluop: ALUOP_SUB,   alusrc: 1'b0, regwrite: 1'b0};
            OP_ADDI:  ctrl = '{aluop: ALUOP_ADD,   alusrc: 1'b1, regwrite: 1'b1};
            default:  ctrl = '{aluop: ALUOP_ADD,   alusrc: 1'b0, regwrite: 1'b0};
        endcase
    end

    assign aluop    = ctrl.aluop;
    assign alusrc   = ctrl.alusrc;
    assign regwrite = ctrl.regwrite;

endmodule

// File: rtl/mini_top_level.sv
// Control-path slice top: chains the main controller into the ALU decoder,
// gates every output with a run flag so nothing asserts in or straight out
// of reset, and derives branch_taken for a future PCSrc output.
module mini_top_level
    import mini_top_level_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [2:0]  ALUControl
);

    logic       run_reg;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [1:0] aluop_dec;
    logic       alusrc_dec;
    logic       regwrite_dec;
    logic [2:0] alucontrol_dec;
    logic       branch_taken;
    logic       unused_bits;

    assign opcode = get_opcode(Instruction);
    assign funct  = get_funct(Instruction);

    main_controller u_main_controller (
        .opcode   (opcode),
        .aluop    (aluop_dec),
        .alusrc   (alusrc_dec),
        .regwrite (regwrite_dec)
    );

    alu_control u_alu_control (
        .aluop      (aluop_dec),
        .funct      (funct),
        .alucontrol (alucontrol_dec)
    );

    // Run flag: cleared on any edge sampling Rst, set on the first edge without it
    always_ff @(posedge Clk) begin
        if (Rst) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Outputs follow the instruction with zero latency, forced low while not running
    always_comb begin
        ALUOp      = 2'b00;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALUControl = 3'b000;
        if (run_reg) begin
            ALUOp      = aluop_dec;
            ALUSrc     = alusrc_dec;
            RegWrite   = regwrite_dec;
            ALUControl = alucontrol_dec;
        end
    end

    // Branch decision kept internal until a PCSrc output is added
    assign branch_taken = (opcode == OP_BEQ) & Zero & run_reg;

    // Register fields and branch_taken are not consumed by this slice yet
    assign unused_bits = ^{Instruction[25:6], branch_taken};

endmodule

// File: tb/tb_mini_top_level.sv
// Self-checking bench for mini_top_level: directed steps from the test plan
// followed by random instructions checked against a table-driven model.
module tb_mini_top_level;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instruction;
    logic        Zero;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        RegWrite;
    logic [2:0]  ALUControl;

    int n_checks = 0;
    int n_errors = 0;
    bit run_m    = 1'b0;

    // Decode tables written straight from the instruction-set rules
    logic [5:0] op_tab    [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
    logic [1:0] aluop_tab [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    logic       src_tab   [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       rw_tab    [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [5:0] fn_tab    [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] fnop_tab  [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    mini_top_level dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Instruction (Instruction),
        .Zero        (Zero),
        .ALUOp       (ALUOp),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .ALUControl  (ALUControl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: table lookups on opcode and funct, then the run gate
    task automatic model(input logic [31:0] instr, input bit zero,
                         output logic [1:0] e_aluop, output logic e_src,
                         output logic e_rw, output logic [2:0] e_ctl,
                         output logic e_br);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        e_aluop = 2'b00; e_src = 1'b0; e_rw = 1'b0;
        for (int i = 0; i < 5; i++)
            if (op_tab[i] == op) begin
                e_aluop = aluop_tab[i]; e_src = src_tab[i]; e_rw = rw_tab[i];
            end
        if (e_aluop == 2'b00)      e_ctl = 3'b010;
        else if (e_aluop == 2'b01) e_ctl = 3'b110;
        else begin
            e_ctl = 3'b000;
            for (int i = 0; i < 5; i++)
                if (fn_tab[i] == fn) e_ctl = fnop_tab[i];
        end
        e_br = (op == 6'h04) && zero;
        if (!run_m) begin
            e_aluop = 2'b00; e_src = 1'b0; e_rw = 1'b0; e_ctl = 3'b000; e_br = 1'b0;
        end
    endtask

    // Drive one instruction just after a rising edge, check at the falling
    // edge, then advance to the next rising edge and update the model's run flag
    task automatic step(input string tag, input logic [31:0] instr, input bit zero);
        logic [1:0] e_aluop;
        logic       e_src, e_rw, e_br;
        logic [2:0] e_ctl;
        Instruction = instr;
        Zero        = zero;
        @(negedge Clk);
        model(instr, zero, e_aluop, e_src, e_rw, e_ctl, e_br);
        $display("step %s instr=%08h zero=%0b run=%0b -> aluop=%b alusrc=%b regwrite=%b aluctl=%b",
                 tag, instr, zero, run_m, ALUOp, ALUSrc, RegWrite, ALUControl);
        check({tag, ".aluop"},    32'(ALUOp),      32'(e_aluop));
        check({tag, ".alusrc"},   32'(ALUSrc),     32'(e_src));
        check({tag, ".regwrite"}, 32'(RegWrite),   32'(e_rw));
        check({tag, ".aluctl"},   32'(ALUControl), 32'(e_ctl));
        check({tag, ".branch"},   32'(dut.branch_taken), 32'(e_br));
        @(posedge Clk);
        run_m = !Rst;
        #1;
    endtask

    initial begin
        logic [31:0] instr;
        int          k;
        Rst = 1'b1;
        Instruction = 32'h00221820;
        Zero = 1'b0;
        @(posedge Clk);
        run_m = 1'b0;
        #1;

        // Two reset cycles with an ADD on the bus: everything must stay low
        step("rst0", 32'h00221820, 1'b0);
        step("rst1", 32'h00221820, 1'b1);
        Rst = 1'b0;
        // Cycle straight after release: run flag not yet set
        step("release", 32'h00221820, 1'b0);
        // Directed instruction set coverage
        step("add",    32'h00221820, 1'b0);
        step("lw",     32'h8C220000, 1'b0);
        step("sw",     32'hAC220000, 1'b0);
        step("beq_z0", 32'h10220004, 1'b0);
        step("beq_z1", 32'h10220004, 1'b1);
        step("sub",    32'h00221822, 1'b0);
        step("and",    32'h00221824, 1'b0);
        step("or",     32'h00221825, 1'b0);
        step("slt",    32'h0022182A, 1'b0);
        step("fn0",    32'h00221800, 1'b0);
        step("addi",   32'h20220007, 1'b0);
        step("badop",  32'hFC221820, 1'b1);

        // Random instructions biased toward known opcodes and functs
        for (int i = 0; i < 40; i++) begin
            instr = $urandom;
            k = $urandom_range(0, 6);
            if (k < 5) instr[31:26] = op_tab[k];
            k = $urandom_range(0, 6);
            if (k < 5) instr[5:0] = fn_tab[k];
            step($sformatf("rnd%0d", i), instr, 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream: outputs drop from the edge that samples Rst
        Rst = 1'b1;
        step("midrst_pre", 32'h00221820, 1'b1);
        step("midrst0",    32'h00221820, 1'b0);
        step("midrst_beq", 32'h10220004, 1'b1);
        Rst = 1'b0;
        step("rerelease",  32'h8C220000, 1'b0);
        step("rerun_lw",   32'h8C220000, 1'b0);
        step("rerun_beq",  32'h10220004, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
